vtile_cfg_sched: RTL and testbench
==================================

VTILE_CFG_SCHED -- requirements
Module: vtile_cfg_sched

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning data word width.
REQ-002 The block SHALL have parameter NUM_INPUTS, default 8, meaning that data arrays have NUM_INPUTS+1 entries.
REQ-003 The block SHALL have parameter LEN_W, default 8, meaning the width of the execution length field.
REQ-004 The block SHALL have parameter TIMEOUT, default 64, meaning the maximum write-wait cycles before abort.
REQ-005 The block SHALL have one clock; reset is asynchronous and active-high. The ports SHALL be: clk  in  1  rising-edge clock.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 net_wr_req  in  1  network write request, a level held until done or err.
REQ-008 net_wr_data  in  WIDTH x (NUM_INPUTS+1)  write payload.
REQ-009 net_wr_done  out  1  one-cycle pulse indicating the write was acknowledged.
REQ-010 net_wr_err  out  1  one-cycle pulse indicating the write timed out.
REQ-011 fu_exec_req  in  1  vector FU execute request, a level held until done.
REQ-012 fu_exec_len  in  LEN_W  number of execution cycles.
REQ-013 fu_exec_done  out  1  one-cycle pulse indicating execution finished.
REQ-014 cm_write_en  out  1  drives the register-file write enable.
REQ-015 cm_w_data  out  WIDTH x (NUM_INPUTS+1)  latched write payload.
REQ-016 cm_write_rdy  in  1  register file ready for a write.
REQ-017 cm_write_ack  in  1  register file write acknowledge.
REQ-018 cm_on_off  out  1  register-file read and FU execution enable.
REQ-019 busy  out  1  high whenever the state is not IDLE.
REQ-020 state  out  2  current FSM state: IDLE=0, WR=1, EXEC=2, GAP=3.

Function
REQ-021 All outputs SHALL be registered; cm_write_en and cm_on_off SHALL never be high in the same cycle.
REQ-022 The FSM SHALL have the states IDLE, WR, EXEC and GAP, and SHALL make exactly one transition decision per clock.
REQ-023 A write in IDLE SHALL be eligible only when net_wr_req=1 and cm_write_rdy=1; an execution in IDLE SHALL be eligible when fu_exec_req=1.
REQ-024 Arbitration SHALL be round-robin: when both requests are eligible, grant the type not granted last (last_grant register, reset value EXEC, so the first contention goes to the write).
REQ-025 A write grant SHALL latch net_wr_data into cm_w_data, move the FSM to WR, and set cm_write_en=1 in the next cycle (1-cycle latency from request to write_en).
REQ-026 In WR, cm_write_en SHALL remain 1 until cm_write_ack is sampled 1; on the next cycle cm_write_en=0, net_wr_done=1 for that one cycle, and the FSM moves to GAP.
REQ-027 In WR, a wait counter SHALL count cycles with cm_write_ack=0; when the count reaches TIMEOUT, the block SHALL deassert cm_write_en, pulse net_wr_err for one cycle, and move to GAP.
REQ-028 If cm_write_ack=1 in the same cycle that the timeout is reached, the ack SHALL win (done, no err).
REQ-029 An execution grant SHALL latch fu_exec_len, with a value of 0 treated as 1, move the FSM to EXEC, and hold cm_on_off=1 for exactly the latched number of cycles.
REQ-030 fu_exec_done SHALL pulse in the first cycle after cm_on_off falls, coinciding with entry to GAP.
REQ-031 GAP SHALL last exactly one cycle with cm_write_en=0 and cm_on_off=0, then the FSM returns to IDLE; arbitration resumes in IDLE the following cycle.
REQ-032 Changes to a request, data, or length after grant SHALL be ignored until the operation ends; a request deasserted before grant SHALL be dropped silently.
REQ-033 cm_w_data SHALL retain its last latched value outside WR.
REQ-034 The wait and execution counters SHALL be sized to hold TIMEOUT and 2^LEN_W-1 respectively without wrap.

Reset
REQ-035 On reset assertion, the block SHALL asynchronously force state=IDLE, all 1-bit outputs=0, cm_w_data=0, counters=0, and last_grant=EXEC.
REQ-036 A reset asserted mid-operation SHALL abort the operation with no done or err pulse; operation SHALL resume on the first rising clk after reset deasserts.

Verification
REQ-037 Write only: net_wr_req=1 with cm_write_rdy=1 and ack returned 3 cycles after write_en rises -> write_en is high for 3 cycles, net_wr_done is a single pulse, and the block is in GAP then IDLE.
REQ-038 Execute only: fu_exec_req=1 with fu_exec_len=5 -> cm_on_off is high for exactly 5 cycles, fu_exec_done pulses in the 6th cycle, and write_en stays 0 throughout.
REQ-039 Contention: both requests are held continuously from reset -> grant order is WR, EXEC, WR, EXEC with a 1-cycle GAP between each.
REQ-040 Timeout: ack is tied to 0 with TIMEOUT=64 -> write_en is high for 64 cycles, then net_wr_err pulses once and net_wr_done never pulses; a variant with ack arriving on cycle 64 -> done pulses, err does not.
REQ-041 Edge length and reset: fu_exec_len=0 -> exactly 1 on_off cycle; reset asserted at on_off cycle 2 of a len=10 execution -> on_off drops immediately and no fu_exec_done pulse occurs.

Source files
------------

// File: rtl/vtile_cfg_sched_if.sv
// rtl/vtile_cfg_sched_if.sv - network-write / FU-execute / register-file handshake bundle
interface vtile_cfg_sched_if #(
    parameter int WIDTH      = 16,
    parameter int NUM_INPUTS = 8,
    parameter int LEN_W      = 8
);
    logic                             net_wr_req;
    logic [NUM_INPUTS:0][WIDTH-1:0]   net_wr_data;
    logic                             net_wr_done;
    logic                             net_wr_err;
    logic                             fu_exec_req;
    logic [LEN_W-1:0]                 fu_exec_len;
    logic                             fu_exec_done;
    logic                             cm_write_en;
    logic [NUM_INPUTS:0][WIDTH-1:0]   cm_w_data;
    logic                             cm_write_rdy;
    logic                             cm_write_ack;
    logic                             cm_on_off;
    logic                             busy;
    logic [1:0]                       state;

    modport slave (
        input  net_wr_req, net_wr_data, fu_exec_req, fu_exec_len,
               cm_write_rdy, cm_write_ack,
        output net_wr_done, net_wr_err, fu_exec_done, cm_write_en,
               cm_w_data, cm_on_off, busy, state
    );

    modport master (
        output net_wr_req, net_wr_data, fu_exec_req, fu_exec_len,
               cm_write_rdy, cm_write_ack,
        input  net_wr_done, net_wr_err, fu_exec_done, cm_write_en,
               cm_w_data, cm_on_off, busy, state
    );
endinterface

// File: rtl/vtile_cfg_sched.sv
// rtl/vtile_cfg_sched.sv - round-robin scheduler between register-file writes and FU execution
module vtile_cfg_sched #(
    parameter int WIDTH      = 16,
    parameter int NUM_INPUTS = 8,
    parameter int LEN_W      = 8,
    parameter int TIMEOUT    = 64
) (
    input  logic               clk,
    input  logic               reset,
    vtile_cfg_sched_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WR   = 2'd1,
        S_EXEC = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    localparam int   WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic G_WR   = 1'b0;
    localparam logic G_EXEC = 1'b1;

    state_t                         r_state;
    state_t                         w_next_state;
    logic                           r_last_grant;
    logic [WAIT_W-1:0]              r_wait_cnt;
    logic [LEN_W-1:0]               r_exec_cnt;
    logic [NUM_INPUTS:0][WIDTH-1:0] r_w_data;
    logic                           r_write_en;
    logic                           r_on_off;
    logic                           r_wr_done;
    logic                           r_wr_err;
    logic                           r_exec_done;
    logic                           r_busy;

    logic                           w_wr_elig;
    logic                           w_ex_elig;
    logic                           w_grant_wr;
    logic                           w_grant_ex;
    logic [WAIT_W-1:0]              w_wait_inc;
    logic                           w_wr_end_ok;
    logic                           w_wr_end_to;
    logic                           w_ex_end;

    logic                           w_nx_last_grant;
    logic [WAIT_W-1:0]              w_nx_wait_cnt;
    logic [LEN_W-1:0]               w_nx_exec_cnt;
    logic [NUM_INPUTS:0][WIDTH-1:0] w_nx_w_data;
    logic                           w_nx_write_en;
    logic                           w_nx_on_off;
    logic                           w_nx_wr_done;
    logic                           w_nx_wr_err;
    logic                           w_nx_exec_done;
    logic                           w_nx_busy;

    assign w_wr_elig  = bus.net_wr_req & bus.cm_write_rdy;
    assign w_ex_elig  = bus.fu_exec_req;
    // Write wins unless both are eligible and write was the previous grant.
    assign w_grant_wr = (r_state == S_IDLE) && w_wr_elig &&
                        (!w_ex_elig || (r_last_grant == G_EXEC));
    assign w_grant_ex = (r_state == S_IDLE) && w_ex_elig && !w_grant_wr;

    assign w_wait_inc  = r_wait_cnt + WAIT_W'(1);
    // Ack is checked first so an ack on the timeout cycle still completes the write.
    assign w_wr_end_ok = (r_state == S_WR) && bus.cm_write_ack;
    assign w_wr_end_to = (r_state == S_WR) && !bus.cm_write_ack &&
                         (w_wait_inc == WAIT_W'(TIMEOUT));
    assign w_ex_end    = (r_state == S_EXEC) && (r_exec_cnt == LEN_W'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_last_grant <= G_EXEC;
            r_wait_cnt   <= '0;
            r_exec_cnt   <= '0;
            r_w_data     <= '0;
            r_write_en   <= 1'b0;
            r_on_off     <= 1'b0;
            r_wr_done    <= 1'b0;
            r_wr_err     <= 1'b0;
            r_exec_done  <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_last_grant <= w_nx_last_grant;
            r_wait_cnt   <= w_nx_wait_cnt;
            r_exec_cnt   <= w_nx_exec_cnt;
            r_w_data     <= w_nx_w_data;
            r_write_en   <= w_nx_write_en;
            r_on_off     <= w_nx_on_off;
            r_wr_done    <= w_nx_wr_done;
            r_wr_err     <= w_nx_wr_err;
            r_exec_done  <= w_nx_exec_done;
            r_busy       <= w_nx_busy;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_grant_wr)      w_next_state = S_WR;
                else if (w_grant_ex) w_next_state = S_EXEC;
            end
            S_WR:    if (w_wr_end_ok || w_wr_end_to) w_next_state = S_GAP;
            S_EXEC:  if (w_ex_end) w_next_state = S_GAP;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Next values of the registered outputs, derived from the decided transition.
    always_comb begin
        w_nx_write_en   = (w_next_state == S_WR);
        w_nx_on_off     = (w_next_state == S_EXEC);
        w_nx_busy       = (w_next_state != S_IDLE);
        w_nx_wr_done    = w_wr_end_ok;
        w_nx_wr_err     = w_wr_end_to;
        w_nx_exec_done  = w_ex_end;
        w_nx_last_grant = r_last_grant;
        w_nx_w_data     = r_w_data;
        w_nx_wait_cnt   = r_wait_cnt;
        w_nx_exec_cnt   = r_exec_cnt;
        if (w_grant_wr) begin
            w_nx_last_grant = G_WR;
            w_nx_w_data     = bus.net_wr_data;
            w_nx_wait_cnt   = '0;
        end else if (w_grant_ex) begin
            w_nx_last_grant = G_EXEC;
            w_nx_exec_cnt   = (bus.fu_exec_len == '0) ? LEN_W'(1) : bus.fu_exec_len;
        end
        if ((r_state == S_WR) && !bus.cm_write_ack)
            w_nx_wait_cnt = w_wait_inc;
        if ((r_state == S_EXEC) && !w_ex_end)
            w_nx_exec_cnt = r_exec_cnt - LEN_W'(1);
    end

    assign bus.state        = r_state;
    assign bus.busy         = r_busy;
    assign bus.cm_write_en  = r_write_en;
    assign bus.cm_on_off    = r_on_off;
    assign bus.cm_w_data    = r_w_data;
    assign bus.net_wr_done  = r_wr_done;
    assign bus.net_wr_err   = r_wr_err;
    assign bus.fu_exec_done = r_exec_done;
endmodule

// File: tb/tb_vtile_cfg_sched.sv
// tb/tb_vtile_cfg_sched.sv - directed self-checking bench for vtile_cfg_sched
module tb_vtile_cfg_sched;
    localparam int WIDTH = 16;
    localparam int NUM_INPUTS = 8;
    localparam int LEN_W = 8;
    localparam int TIMEOUT = 64;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    logic [NUM_INPUTS:0][WIDTH-1:0] data_a;
    logic [NUM_INPUTS:0][WIDTH-1:0] data_b;

    vtile_cfg_sched_if #(.WIDTH(WIDTH), .NUM_INPUTS(NUM_INPUTS), .LEN_W(LEN_W)) bus ();

    vtile_cfg_sched #(.WIDTH(WIDTH), .NUM_INPUTS(NUM_INPUTS), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        chk("excl", 256'(bus.cm_write_en & bus.cm_on_off), 256'(0));
    endtask

    initial begin
        for (int i = 0; i <= NUM_INPUTS; i++) begin
            data_a[i] = 16'h1000 + 16'(i * 16'h0111);
            data_b[i] = 16'hA5A5 ^ 16'(i);
        end
        bus.net_wr_req   = 1'b0;
        bus.net_wr_data  = '0;
        bus.fu_exec_req  = 1'b0;
        bus.fu_exec_len  = '0;
        bus.cm_write_rdy = 1'b0;
        bus.cm_write_ack = 1'b0;

        // Reset state
        cyc(); cyc();
        chk("rst_state", 256'(bus.state), 256'(0));
        chk("rst_busy", 256'(bus.busy), 256'(0));
        chk("rst_we", 256'(bus.cm_write_en), 256'(0));
        chk("rst_onoff", 256'(bus.cm_on_off), 256'(0));
        chk("rst_wdata", 256'(bus.cm_w_data), 256'(0));
        chk("rst_pulses", 256'({bus.net_wr_done, bus.net_wr_err, bus.fu_exec_done}), 256'(0));
        reset = 1'b0;

        // Write only, ack sampled in third write_en cycle
        bus.net_wr_data = data_a; bus.net_wr_req = 1'b1; bus.cm_write_rdy = 1'b1;
        cyc();
        chk("wr_we1", 256'(bus.cm_write_en), 256'(1));
        chk("wr_state", 256'(bus.state), 256'(1));
        chk("wr_busy", 256'(bus.busy), 256'(1));
        chk("wr_data", 256'(bus.cm_w_data), 256'(data_a));
        bus.net_wr_data = data_b;
        cyc(); chk("wr_we2", 256'(bus.cm_write_en), 256'(1));
        cyc(); chk("wr_we3", 256'(bus.cm_write_en), 256'(1));
        bus.cm_write_ack = 1'b1;
        cyc();
        chk("wr_we_fall", 256'(bus.cm_write_en), 256'(0));
        chk("wr_done", 256'(bus.net_wr_done), 256'(1));
        chk("wr_noerr", 256'(bus.net_wr_err), 256'(0));
        chk("wr_gap", 256'(bus.state), 256'(3));
        chk("wr_data_held", 256'(bus.cm_w_data), 256'(data_a));
        bus.cm_write_ack = 1'b0; bus.net_wr_req = 1'b0;
        cyc();
        chk("wr_done_once", 256'(bus.net_wr_done), 256'(0));
        chk("wr_idle", 256'(bus.state), 256'(0));
        chk("wr_idle_busy", 256'(bus.busy), 256'(0));
        chk("wr_data_retain", 256'(bus.cm_w_data), 256'(data_a));

        // Write request without rdy, dropped before grant
        bus.cm_write_rdy = 1'b0; bus.net_wr_req = 1'b1;
        cyc(); chk("norrdy_idle", 256'(bus.state), 256'(0));
        bus.net_wr_req = 1'b0; bus.cm_write_rdy = 1'b1;
        cyc(); chk("drop_idle", 256'(bus.state), 256'(0));
        chk("drop_we", 256'(bus.cm_write_en), 256'(0));

        // Execute len=5, length change after grant ignored
        bus.fu_exec_req = 1'b1; bus.fu_exec_len = 8'd5;
        for (int i = 1; i <= 5; i++) begin
            cyc();
            chk("ex5_onoff", 256'(bus.cm_on_off), 256'(1));
            chk("ex5_we", 256'(bus.cm_write_en), 256'(0));
            chk("ex5_state", 256'(bus.state), 256'(2));
            chk("ex5_nodone", 256'(bus.fu_exec_done), 256'(0));
            if (i == 1) bus.fu_exec_len = 8'd2;
        end
        cyc();
        chk("ex5_off", 256'(bus.cm_on_off), 256'(0));
        chk("ex5_done", 256'(bus.fu_exec_done), 256'(1));
        chk("ex5_gap", 256'(bus.state), 256'(3));
        chk("ex5_we_off", 256'(bus.cm_write_en), 256'(0));
        bus.fu_exec_req = 1'b0;
        cyc();
        chk("ex5_done_once", 256'(bus.fu_exec_done), 256'(0));
        chk("ex5_idle", 256'(bus.state), 256'(0));

        // Execute len=0 behaves as len=1
        bus.fu_exec_req = 1'b1; bus.fu_exec_len = 8'd0;
        cyc(); chk("ex0_onoff", 256'(bus.cm_on_off), 256'(1));
        cyc();
        chk("ex0_off", 256'(bus.cm_on_off), 256'(0));
        chk("ex0_done", 256'(bus.fu_exec_done), 256'(1));
        bus.fu_exec_req = 1'b0;
        cyc(); chk("ex0_idle", 256'(bus.state), 256'(0));

        // Contention from reset: WR, EXEC, WR, EXEC
        reset = 1'b1;
        bus.net_wr_data = data_b; bus.net_wr_req = 1'b1; bus.cm_write_rdy = 1'b1;
        bus.fu_exec_req = 1'b1; bus.fu_exec_len = 8'd2;
        cyc();
        reset = 1'b0;
        cyc(); chk("ct_g1_wr", 256'(bus.state), 256'(1));
        chk("ct_g1_data", 256'(bus.cm_w_data), 256'(data_b));
        bus.cm_write_ack = 1'b1;
        cyc(); chk("ct_gap1", 256'(bus.state), 256'(3));
        bus.cm_write_ack = 1'b0;
        cyc(); chk("ct_idle1", 256'(bus.state), 256'(0));
        cyc(); chk("ct_g2_ex", 256'(bus.state), 256'(2));
        cyc(); chk("ct_g2_ex2", 256'(bus.state), 256'(2));
        cyc(); chk("ct_gap2", 256'(bus.state), 256'(3));
        chk("ct_exdone", 256'(bus.fu_exec_done), 256'(1));
        cyc(); chk("ct_idle2", 256'(bus.state), 256'(0));
        cyc(); chk("ct_g3_wr", 256'(bus.state), 256'(1));
        bus.cm_write_ack = 1'b1;
        cyc(); chk("ct_gap3", 256'(bus.state), 256'(3));
        bus.cm_write_ack = 1'b0;
        cyc(); chk("ct_idle3", 256'(bus.state), 256'(0));
        cyc(); chk("ct_g4_ex", 256'(bus.state), 256'(2));
        bus.net_wr_req = 1'b0; bus.fu_exec_req = 1'b0;
        cyc(); chk("ct_g4_ex2", 256'(bus.state), 256'(2));
        cyc(); chk("ct_gap4", 256'(bus.state), 256'(3));
        cyc(); chk("ct_idle4", 256'(bus.state), 256'(0));

        // Timeout with ack tied low
        bus.net_wr_data = data_a; bus.net_wr_req = 1'b1;
        for (int i = 1; i <= TIMEOUT; i++) begin
            cyc();
            chk("to_we", 256'(bus.cm_write_en), 256'(1));
            chk("to_noerr", 256'(bus.net_wr_err), 256'(0));
        end
        cyc();
        chk("to_we_off", 256'(bus.cm_write_en), 256'(0));
        chk("to_err", 256'(bus.net_wr_err), 256'(1));
        chk("to_nodone", 256'(bus.net_wr_done), 256'(0));
        chk("to_gap", 256'(bus.state), 256'(3));
        bus.net_wr_req = 1'b0;
        cyc();
        chk("to_err_once", 256'(bus.net_wr_err), 256'(0));
        chk("to_idle", 256'(bus.state), 256'(0));

        // Ack on the timeout cycle wins
        bus.net_wr_req = 1'b1;
        for (int i = 1; i < TIMEOUT; i++) begin
            cyc();
            chk("ta_we", 256'(bus.cm_write_en), 256'(1));
        end
        cyc();
        chk("ta_we64", 256'(bus.cm_write_en), 256'(1));
        bus.cm_write_ack = 1'b1;
        cyc();
        chk("ta_done", 256'(bus.net_wr_done), 256'(1));
        chk("ta_noerr", 256'(bus.net_wr_err), 256'(0));
        chk("ta_we_off", 256'(bus.cm_write_en), 256'(0));
        bus.cm_write_ack = 1'b0; bus.net_wr_req = 1'b0;
        cyc(); chk("ta_idle", 256'(bus.state), 256'(0));

        // Reset during a len=10 execution
        bus.fu_exec_req = 1'b1; bus.fu_exec_len = 8'd10;
        cyc(); chk("rx_on1", 256'(bus.cm_on_off), 256'(1));
        cyc(); chk("rx_on2", 256'(bus.cm_on_off), 256'(1));
        reset = 1'b1;
        #1;
        chk("rx_off_now", 256'(bus.cm_on_off), 256'(0));
        chk("rx_state", 256'(bus.state), 256'(0));
        chk("rx_wdata", 256'(bus.cm_w_data), 256'(0));
        bus.fu_exec_req = 1'b0;
        cyc(); chk("rx_nodone1", 256'(bus.fu_exec_done), 256'(0));
        reset = 1'b0;
        cyc();
        chk("rx_nodone2", 256'(bus.fu_exec_done), 256'(0));
        chk("rx_idle", 256'(bus.state), 256'(0));

        // Resumes normally after reset
        bus.fu_exec_req = 1'b1; bus.fu_exec_len = 8'd1;
        cyc(); chk("rs_on", 256'(bus.cm_on_off), 256'(1));
        bus.fu_exec_req = 1'b0;
        cyc(); chk("rs_done", 256'(bus.fu_exec_done), 256'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
